// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: default sizes, opcode and FSM state encodings shared by the controller and its bench
package regfile_ctrl_pkg;

    localparam int DEF_DATA_W   = 3;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_NUM_REGS = 3;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_COPY  = 2'd2,
        OP_INC   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR       = 3'd3,
        S_RSP      = 3'd4
    } state_e;

    function automatic logic uses_b(input op_e op);
        return op == OP_READ || op == OP_COPY;
    endfunction

endpackage

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: one-command-at-a-time initiator for a small register file with registered reads
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_a,
    input  logic [ADDR_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rsp_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_reg1,
    output logic [ADDR_W-1:0] rd_reg2,
    input  logic [DATA_W-1:0] reg_data1,
    input  logic [DATA_W-1:0] reg_data2
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    op_e               op_in;
    logic              bad;

    assign cmd_ready = state == S_IDLE;

    always_comb begin
        op_in = op_e'(cmd_op);
        bad   = cmd_a >= ADDR_W'(NUM_REGS) || (uses_b(op_in) && cmd_b >= ADDR_W'(NUM_REGS));
    end

    // Outputs are registered on the transition edge, so wr_en is high exactly while in S_WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_READ;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data1 <= '0;
            rsp_data2 <= '0;
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            rd_reg1   <= '0;
            rd_reg2   <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q      <= op_in;
                    a_q       <= cmd_a;
                    b_q       <= cmd_b;
                    rsp_err   <= bad;
                    rsp_data1 <= '0;
                    rsp_data2 <= '0;
                    if (bad) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end else if (op_in == OP_WRITE) begin
                        wr_en   <= 1'b1;
                        wr_reg  <= cmd_a;
                        wr_data <= cmd_data;
                        state   <= S_WR;
                    end else begin
                        rd_reg1 <= cmd_a;
                        rd_reg2 <= op_in == OP_INC ? cmd_a : cmd_b;
                        state   <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: state <= S_RD_DATA;
                S_RD_DATA: if (op_q == OP_READ) begin
                    rsp_data1 <= reg_data1;
                    rsp_data2 <= reg_data2;
                    rsp_valid <= 1'b1;
                    state     <= S_RSP;
                end else begin
                    wr_en   <= 1'b1;
                    wr_reg  <= op_q == OP_COPY ? b_q : a_q;
                    wr_data <= op_q == OP_COPY ? reg_data1 : reg_data1 + DATA_W'(1);
                    state   <= S_WR;
                end
                S_WR: begin
                    wr_en     <= 1'b0;
                    rsp_data1 <= wr_data;
                    rsp_valid <= 1'b1;
                    state     <= S_RSP;
                end
                S_RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
